// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Execute-stage forwarding, load-use stalls, branch flushes,
// and a data-memory wait FSM with timeout and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              mem_req_M,
  input  logic              mem_ready_M,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0] fwd_a_s, fwd_b_s;
  logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic       flush_d_s, flush_e_s, flush_w_s;
  logic       lw_stall_s, decode_s, any_stall_s;

  // Memory stage result beats Writeback; R0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m, input logic we_m,
                                         input logic [REG_AW-1:0] rd_w, input logic we_w);
    logic [1:0] sel;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard outputs and next-state logic, combinational from inputs and current state.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    fwd_a_s     = 2'b00;
    fwd_b_s     = 2'b00;
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    stall_e_s   = 1'b0;
    stall_m_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    flush_w_s   = 1'b0;
    decode_s    = 1'b0;
    lw_stall_s  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    case (state_q)
      ST_INIT: begin
        flush_d_s = 1'b1;
        flush_e_s = 1'b1;
        wait_d    = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        fwd_a_s = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b_s = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        if (mem_req_M && !mem_ready_M) begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
          flush_w_s = 1'b1;
          wait_d    = WAIT_ONE;
          state_d   = ST_MEM_WAIT;
        end else begin
          decode_s = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        fwd_a_s = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b_s = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        if (mem_ready_M) begin
          decode_s = 1'b1;
          wait_d   = '0;
          state_d  = ST_RUN;
        end else if (wait_q >= WAIT_LIMIT) begin
          // Timed out: unfreeze with undefined load data and flag it.
          decode_s  = 1'b1;
          mem_err_d = 1'b1;
          wait_d    = '0;
          state_d   = ST_RUN;
        end else begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
          flush_w_s = 1'b1;
          wait_d    = wait_q + WAIT_ONE;
        end
      end
      default: begin
        wait_d  = '0;
        state_d = ST_INIT;
      end
    endcase

    // A taken branch overrides the load-use stall so the target gets fetched.
    if (decode_s) begin
      if (lw_stall_s) begin
        stall_f_s = 1'b1;
        stall_d_s = 1'b1;
        flush_e_s = 1'b1;
      end else begin
        flush_e_s = flush_e_s;
      end
      if (PCSrcE) begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        flush_d_s = 1'b1;
        flush_e_s = 1'b1;
      end else begin
        flush_d_s = flush_d_s;
      end
    end else begin
      flush_d_s = flush_d_s;
    end

    any_stall_s = stall_f_s | stall_d_s | stall_e_s | stall_m_s;
    if (any_stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, wait counter, sticky error and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ForwardAE = fwd_a_s;
  assign ForwardBE = fwd_b_s;
  assign StallF    = stall_f_s;
  assign StallD    = stall_d_s;
  assign StallE    = stall_e_s;
  assign StallM    = stall_m_s;
  assign FlushD    = flush_d_s;
  assign FlushE    = flush_e_s;
  assign FlushW    = flush_w_s;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued as each step is driven,
// then popped and compared on the falling edge (or right after an asynchronous reset).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ready_M;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Packed view: [11:10] FwdA [9:8] FwdB [7:4] StallF/D/E/M [3] FlushD [2] FlushE [1] FlushW [0] mem_err
  localparam logic [11:0] V_IDLE = 12'h000;
  localparam logic [11:0] V_INIT = 12'h00C;
  localparam logic [11:0] V_LU   = 12'h0C4;
  localparam logic [11:0] V_BR   = 12'h00C;
  localparam logic [11:0] V_MEM  = 12'h0F2;
  localparam logic [11:0] V_FAM  = 12'h800;
  localparam logic [11:0] V_FAW  = 12'h400;
  localparam logic [11:0] V_FBW  = 12'h100;
  localparam logic [11:0] V_FBM  = 12'h200;

  logic [11:0] exp_q[$];
  logic [15:0] cnt_q[$];
  string       tag_q[$];
  logic [15:0] exp_cnt;
  logic        err_e;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic compare_front();
    logic [11:0] e, obs;
    logic [15:0] c;
    string t;
    e = exp_q.pop_front();
    c = cnt_q.pop_front();
    t = tag_q.pop_front();
    obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s outputs: observed %h expected %h", t, obs, e);
    end
    vectors++;
    assert (stall_cnt === c) else begin
      miscompares++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", t, stall_cnt, c);
    end
  endtask

  task automatic push_exp(input string tag, input logic [11:0] v);
    logic [11:0] e;
    e = v | {11'b0, err_e};
    exp_q.push_back(e);
    cnt_q.push_back(exp_cnt);
    tag_q.push_back(tag);
    if ((|e[7:4]) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic cyc(input string tag, input logic [11:0] v);
    push_exp(tag, v);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; mem_req_M = 1'b0; mem_ready_M = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    exp_cnt = 16'd0;
    err_e = 1'b0;

    cyc("rst_hold0", V_INIT);
    cyc("rst_hold1", V_INIT);
    reset = 1'b1;
    cyc("init_flush", V_INIT);
    cyc("run_idle", V_IDLE);

    // Forwarding
    RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1; Rs1E = 5'd3; Rs2E = 5'd0;
    cyc("fwd_mem_prio", V_FAM);
    RdM = 5'd0;
    cyc("fwd_wb", V_FAW);
    RdM = 5'd3; RegWriteM = 1'b0; Rs1E = 5'd0; Rs2E = 5'd3;
    cyc("fwd_b_wb", V_FBW);
    RegWriteM = 1'b1; Rs1E = 5'd3;
    cyc("fwd_both_mem", V_FAM | V_FBM);
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    cyc("fwd_r0", V_IDLE);
    clear_inputs();

    // Load-use and control hazards
    ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
    cyc("load_use", V_LU);
    clear_inputs();
    cyc("load_use_done", V_IDLE);
    ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
    cyc("branch_over_lu", V_BR);
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
    cyc("lu_r0", V_IDLE);
    ResultSrcE = 2'b00; RdE = 5'd7; Rs1D = 5'd7;
    cyc("not_load", V_IDLE);
    clear_inputs();

    // Memory wait: hazards ignored while frozen, forwarding still active
    mem_req_M = 1'b1; mem_ready_M = 1'b0;
    cyc("miss_run", V_MEM);
    ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
    cyc("wait_ignore_hz", V_MEM);
    clear_inputs();
    mem_req_M = 1'b1; Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
    cyc("wait_fwd", V_MEM | V_FAM);
    clear_inputs();
    mem_req_M = 1'b1; mem_ready_M = 1'b1;
    cyc("ready_release", V_IDLE);
    cyc("hit_no_stall", V_IDLE);
    mem_ready_M = 1'b0;
    cyc("b2b_miss1", V_MEM);
    mem_ready_M = 1'b1;
    cyc("b2b_rel1", V_IDLE);
    mem_ready_M = 1'b0;
    cyc("b2b_miss2", V_MEM);
    mem_ready_M = 1'b1;
    cyc("b2b_rel2", V_IDLE);

    // Timeout: 15 frozen cycles, released on the 16th, sticky error afterwards
    mem_ready_M = 1'b0;
    for (int i = 0; i < 15; i++) cyc("timeout_freeze", V_MEM);
    cyc("timeout_release", V_IDLE);
    err_e = 1'b1;
    mem_req_M = 1'b0;
    cyc("err_sticky0", V_IDLE);
    cyc("err_sticky1", V_IDLE);

    // Asynchronous reset in the middle of MEM_WAIT
    mem_req_M = 1'b1; mem_ready_M = 1'b0;
    cyc("pre_rst_miss", V_MEM);
    cyc("pre_rst_wait", V_MEM);
    #2;
    reset = 1'b0;
    err_e = 1'b0;
    exp_cnt = 16'd0;
    #1;
    push_exp("async_rst", V_INIT);
    compare_front();
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_inputs();
    cyc("post_rst_init", V_INIT);
    cyc("post_rst_idle", V_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
